// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Time-multiplexed N-digit hex 7-segment driver. A value is captured into a
// pending register by i_load and promoted to the active register only at the
// end of a full scan, so a frame never mixes two loads. Each digit slot is a
// GUARD period (everything dark, anti-ghosting) followed by a DISPLAY period.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   i_value        4*NUM_DIGITS hex nibbles, nibble k -> digit k (0 = LSD)
//   i_dp           decimal point request per digit
//   i_digit_en     per-digit enable (0 blanks the digit slot)
//   i_lz_suppress  leading-zero suppression enable (sampled live)
//   i_load         1-cycle strobe capturing value/dp/enables into pending
//   o_seg          segments a..g on bit6..bit0 (polarity by SEG_ACTIVE_LOW)
//   o_dp           decimal point segment (polarity by SEG_ACTIVE_LOW)
//   o_dig          one-hot digit select (polarity by DIG_ACTIVE_LOW)
//   o_frame_done   1-cycle pulse in the last DISPLAY cycle of the last digit
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int GUARD_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic                    i_lz_suppress,
    input  logic                    i_load,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_dig,
    output logic                    o_frame_done
);

    localparam int CNT_MAX = (CLK_DIV > GUARD_CYCLES) ? CLK_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_INV = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    typedef enum logic {
        ST_GUARD   = 1'b0,
        ST_DISPLAY = 1'b1
    } state_t;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   en;
    } frame_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    frame_t pending, active, incoming;
    logic   dirty;

    logic [3:0]            nibble;
    logic                  zeros_above;
    logic                  lz_blank;
    logic                  slot_en;
    logic                  slot_dp;
    logic                  lit;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] dig_d;
    logic                  frame_d;

    assign incoming = {i_value, i_dp, i_digit_en};

    function automatic logic [6:0] decode(input logic [3:0] hex);
        case (hex)
            4'h0: decode = 7'h7E;
            4'h1: decode = 7'h30;
            4'h2: decode = 7'h6D;
            4'h3: decode = 7'h79;
            4'h4: decode = 7'h33;
            4'h5: decode = 7'h5B;
            4'h6: decode = 7'h5F;
            4'h7: decode = 7'h70;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h7B;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h1F;
            4'hC: decode = 7'h4E;
            4'hD: decode = 7'h3D;
            4'hE: decode = 7'h4F;
            default: decode = 7'h47;
        endcase
    endfunction

    // Scan sequencer: next state, counter and digit index.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned (which would infer a latch).
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        case (state_q)
            ST_GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
                    state_d = ST_DISPLAY;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end
        endcase
        frame_d = (state_d == ST_DISPLAY) && (idx_d == IDX_W'(NUM_DIGITS - 1))
                  && (cnt_d == CNT_W'(CLK_DIV - 1));
    end

    // Output content for the upcoming cycle. Outputs are registered from the
    // next-state view so they line up with the state register.
    always_comb begin
        nibble      = 4'h0;
        zeros_above = 1'b1;
        lz_blank    = 1'b0;
        slot_en     = 1'b0;
        slot_dp     = 1'b0;
        // Walk from the most significant digit down, so zeros_above holds
        // "this nibble and everything above it is zero" at digit k.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zeros_above = zeros_above & (active.value[4*k +: 4] == 4'h0);
            if (idx_d == IDX_W'(k)) begin
                nibble   = active.value[4*k +: 4];
                lz_blank = zeros_above && (k != 0);
                slot_en  = active.en[k];
                slot_dp  = active.dp[k];
            end
        end
        lit   = (state_d == ST_DISPLAY) && slot_en;
        // A suppressed leading zero keeps its digit select so its dp can light.
        seg_d = (lit && !(i_lz_suppress && lz_blank)) ? decode(nibble) : 7'h00;
        dp_d  = lit && slot_dp;
        dig_d = lit ? (NUM_DIGITS'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q      <= ST_GUARD;
            cnt_q        <= '0;
            idx_q        <= '0;
            o_seg        <= SEG_INV;
            o_dp         <= SEG_ACTIVE_LOW;
            o_dig        <= DIG_INV;
            o_frame_done <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            o_seg        <= seg_d ^ SEG_INV;
            o_dp         <= dp_d ^ SEG_ACTIVE_LOW;
            o_dig        <= dig_d ^ DIG_INV;
            o_frame_done <= frame_d;
        end
    end

    // Update path: pending collects loads; active changes only on the edge
    // that closes a frame, so a frame is always drawn from one load.
    always_ff @(posedge clk) begin
        // NOTE: the value registers are reset too, because the display must
        // come up dark rather than showing whatever powered up in them.
        if (!rst_n) begin
            pending <= '0;
            active  <= '0;
            dirty   <= 1'b0;
        end else if (o_frame_done) begin
            if (i_load) begin
                pending <= incoming;
                active  <= incoming;
                dirty   <= 1'b0;
            end else if (dirty) begin
                active  <= pending;
                dirty   <= 1'b0;
            end
        end else if (i_load) begin
            pending <= incoming;
            dirty   <= 1'b1;
        end
    end

endmodule
